// File: rtl/cscv2_pkg.sv
// ---------------------------------------------------------------------------
// cscv2_pkg
// Shared definitions for the CSCv2 control path.
//   seq_state_t        : sequencer state encoding (RUN / HALT / STEP)
//   FLAG_N/Z/V/C       : bit positions of the flags inside the NZVC vector
//   CSC_ADDR_W         : default control-ROM address (PC) width
// ---------------------------------------------------------------------------
package cscv2_pkg;

    typedef enum logic [1:0] {
        SEQ_RUN  = 2'd0,
        SEQ_HALT = 2'd1,
        SEQ_STEP = 2'd2
    } seq_state_t;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_C = 0;

    localparam int unsigned CSC_ADDR_W = 8;

endpackage

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Program counter and NZVC flag register for the CSCv2 control ROM, with
// run / halt / single-step control.
//
// Parameters:
//   ADDR_W     PC width in bits
//   RESET_PC   PC value loaded on reset
//   START_RUN  state after reset: 1 = RUN, 0 = HALT
//
// Ports:
//   clock      in   system clock, rising edge
//   reset_n    in   synchronous active-low reset
//   PCincr     in   1 = PC+1, 0 = load jump_addr
//   jump_addr  in   jump target for the current instruction
//   alu_flags  in   NZVC from the ALU this cycle
//   flags_we   in   capture alu_flags when executing
//   run        in   level request to free-run
//   step       in   one-cycle pulse: execute one instruction while halted
//   halt_req   in   stop after the current instruction
//   PC         out  registered program counter
//   NZVC       out  registered flags
//   exec       out  registered; high in cycles whose instruction executes
//   halted     out  registered; high while in HALT
//
// Build option:
//   PC_SEQ_HALT_DETECT_EN  when defined, an executed jump-to-self forces HALT
// ---------------------------------------------------------------------------
module pc_sequencer
    import cscv2_pkg::*;
#(
    parameter int unsigned       ADDR_W    = CSC_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter bit                START_RUN = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              PCincr,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic [3:0]        alu_flags,
    input  logic              flags_we,
    input  logic              run,
    input  logic              step,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] PC,
    output logic [3:0]        NZVC,
    output logic              exec,
    output logic              halted
);

    seq_state_t        state;
    seq_state_t        state_next;
    logic [ADDR_W-1:0] pc_next;

`ifdef PC_SEQ_HALT_DETECT_EN
    logic self_jump;
    assign self_jump = ~PCincr && (jump_addr == PC);
`endif

    // Modulo-2^ADDR_W increment: the carry-out is simply dropped.
    always_comb begin
        pc_next = PCincr ? (PC + ADDR_W'(1)) : jump_addr;
    end

    // Priority in HALT: halt_req > run > step.
    always_comb begin
        state_next = state;
        case (state)
            SEQ_RUN: begin
                if (halt_req)
                    state_next = SEQ_HALT;
`ifdef PC_SEQ_HALT_DETECT_EN
                else if (self_jump)
                    state_next = SEQ_HALT;
`endif
                else
                    state_next = SEQ_RUN;
            end
            SEQ_HALT: begin
                if (halt_req)
                    state_next = SEQ_HALT;
                else if (run)
                    state_next = SEQ_RUN;
                else if (step)
                    state_next = SEQ_STEP;
                else
                    state_next = SEQ_HALT;
            end
            SEQ_STEP: state_next = SEQ_HALT;
            default:  state_next = SEQ_HALT;
        endcase
    end

    // exec/halted are registered copies of the next-state decode, so they
    // always equal a decode of the current state register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            PC     <= RESET_PC;
            NZVC   <= '0;
            state  <= START_RUN ? SEQ_RUN : SEQ_HALT;
            exec   <= START_RUN;
            halted <= ~START_RUN;
        end else begin
            state  <= state_next;
            exec   <= (state_next != SEQ_HALT);
            halted <= (state_next == SEQ_HALT);
            if (exec) begin
                PC <= pc_next;
                if (flags_we)
                    NZVC <= alu_flags;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Directed bench for pc_sequencer. The driver pushes the expected register
// state for the end of each driven cycle into a queue; an independent
// monitor pops and compares on the falling edge when an entry falls due.
// Honours PC_SEQ_HALT_DETECT_EN for the jump-to-self expectations.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       PCincr;
    logic [7:0] jump_addr;
    logic [3:0] alu_flags;
    logic       flags_we;
    logic       run;
    logic       step;
    logic       halt_req;
    logic [7:0] PC;
    logic [3:0] NZVC;
    logic       exec;
    logic       halted;

    pc_sequencer #(
        .ADDR_W    (8),
        .RESET_PC  (8'h00),
        .START_RUN (1'b1)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .PCincr    (PCincr),
        .jump_addr (jump_addr),
        .alu_flags (alu_flags),
        .flags_we  (flags_we),
        .run       (run),
        .step      (step),
        .halt_req  (halt_req),
        .PC        (PC),
        .NZVC      (NZVC),
        .exec      (exec),
        .halted    (halted)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic [7:0] pc;
        logic [3:0] nzvc;
        logic       ex;
        logic       hl;
        int         due;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: compare every expectation that falls due this cycle.
    always @(negedge clock) begin
        while (q.size() != 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (e.due != cyc || PC !== e.pc || NZVC !== e.nzvc ||
                exec !== e.ex || halted !== e.hl) begin
                errors++;
                $display("FAIL %s: got PC=%h NZVC=%b exec=%b halted=%b, want PC=%h NZVC=%b exec=%b halted=%b",
                         e.name, PC, NZVC, exec, halted, e.pc, e.nzvc, e.ex, e.hl);
            end
        end
    end

    // Drive one cycle of inputs; expectation is for after the next rising edge.
    task automatic drive(input string name,
                         input logic rn, input logic inc, input logic [7:0] ja,
                         input logic [3:0] af, input logic fwe,
                         input logic r, input logic s, input logic h,
                         input logic [7:0] epc, input logic [3:0] enz,
                         input logic eex, input logic ehl);
        exp_t e;
        @(negedge clock);
        reset_n   = rn;
        PCincr    = inc;
        jump_addr = ja;
        alu_flags = af;
        flags_we  = fwe;
        run       = r;
        step      = s;
        halt_req  = h;
        e.name = name; e.pc = epc; e.nzvc = enz; e.ex = eex; e.hl = ehl;
        e.due  = cyc + 1;
        q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    logic [7:0] hpc;
    logic       hd_ex, hd_hl;

    initial begin
`ifdef PC_SEQ_HALT_DETECT_EN
        hpc = 8'h20; hd_ex = 1'b0; hd_hl = 1'b1;
`else
        hpc = 8'h21; hd_ex = 1'b1; hd_hl = 1'b0;
`endif
        //     name          rn inc ja     af       fwe r  s  h   PC     NZVC     ex hl
        drive("reset0",      0, 1, 8'h00, 4'b0000, 0, 0, 0, 0,  8'h00, 4'b0000, 1, 0);
        drive("reset1",      0, 1, 8'h00, 4'b1111, 1, 0, 0, 0,  8'h00, 4'b0000, 1, 0);
        drive("inc01",       1, 1, 8'h00, 4'b0000, 0, 0, 0, 0,  8'h01, 4'b0000, 1, 0);
        drive("inc02",       1, 1, 8'h00, 4'b0000, 0, 0, 0, 0,  8'h02, 4'b0000, 1, 0);
        drive("inc03",       1, 1, 8'h00, 4'b0000, 0, 0, 0, 0,  8'h03, 4'b0000, 1, 0);
        drive("inc04",       1, 1, 8'h00, 4'b0000, 0, 0, 0, 0,  8'h04, 4'b0000, 1, 0);
        drive("inc05",       1, 1, 8'h00, 4'b0000, 0, 0, 0, 0,  8'h05, 4'b0000, 1, 0);
        drive("halt_req",    1, 1, 8'h00, 4'b0000, 0, 0, 0, 1,  8'h06, 4'b0000, 0, 1);
        drive("halt_hold",   1, 1, 8'h00, 4'b0110, 1, 0, 0, 0,  8'h06, 4'b0000, 0, 1);
        drive("step_enter",  1, 1, 8'h00, 4'b0000, 0, 0, 1, 0,  8'h06, 4'b0000, 1, 0);
        drive("step_exec",   1, 1, 8'h00, 4'b0000, 0, 0, 0, 0,  8'h07, 4'b0000, 0, 1);
        drive("step_after",  1, 1, 8'h00, 4'b0000, 0, 0, 0, 0,  8'h07, 4'b0000, 0, 1);
        drive("run_and_hr",  1, 1, 8'h00, 4'b0000, 0, 1, 0, 1,  8'h07, 4'b0000, 0, 1);
        drive("run_and_stp", 1, 1, 8'h00, 4'b0000, 0, 1, 1, 0,  8'h07, 4'b0000, 1, 0);
        drive("run_from07",  1, 1, 8'h00, 4'b0000, 0, 0, 0, 0,  8'h08, 4'b0000, 1, 0);
        drive("jmp10",       1, 0, 8'h10, 4'b0000, 0, 0, 0, 0,  8'h10, 4'b0000, 1, 0);
        drive("jmp42_fwe",   1, 0, 8'h42, 4'b1010, 1, 0, 0, 0,  8'h42, 4'b1010, 1, 0);
        drive("jmp10_nofwe", 1, 0, 8'h10, 4'b0101, 0, 0, 0, 0,  8'h10, 4'b1010, 1, 0);
        drive("jmpFF",       1, 0, 8'hFF, 4'b0000, 0, 0, 0, 0,  8'hFF, 4'b1010, 1, 0);
        drive("wrap00",      1, 1, 8'h00, 4'b0000, 0, 0, 0, 0,  8'h00, 4'b1010, 1, 0);
        drive("inc_fwe",     1, 1, 8'h00, 4'b0011, 1, 0, 0, 0,  8'h01, 4'b0011, 1, 0);
        drive("step_in_run", 1, 1, 8'h00, 4'b0000, 0, 0, 1, 0,  8'h02, 4'b0011, 1, 0);
        drive("jmp20",       1, 0, 8'h20, 4'b0000, 0, 0, 0, 0,  8'h20, 4'b0011, 1, 0);
        drive("self_jump",   1, 0, 8'h20, 4'b1100, 1, 0, 0, 0,  8'h20, 4'b1100, hd_ex, hd_hl);
        drive("self_jump2",  1, 0, 8'h20, 4'b0001, 0, 0, 0, 0,  8'h20, 4'b1100, hd_ex, hd_hl);
        drive("halt_again",  1, 1, 8'h00, 4'b0000, 0, 0, 0, 1,  hpc,   4'b1100, 0, 1);
        drive("step_again",  1, 1, 8'h00, 4'b0000, 0, 0, 1, 0,  hpc,   4'b1100, 1, 0);
        drive("reset_step",  0, 1, 8'h00, 4'b0000, 0, 0, 0, 0,  8'h00, 4'b0000, 1, 0);
        drive("post_reset",  1, 1, 8'h00, 4'b0000, 0, 0, 0, 0,  8'h01, 4'b0000, 1, 0);

        repeat (3) @(negedge clock);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
